// File: rtl/kronos_types.sv
// Shared CLINT definitions: register offsets, bus FSM states, request payload and byte-lane merge.
package kronos_types;

    localparam logic [15:0] CLINT_MSIP      = 16'h0000;
    localparam logic [15:0] CLINT_MTIMECMP  = 16'h4000;
    localparam logic [15:0] CLINT_MTIMECMPH = 16'h4004;
    localparam logic [15:0] CLINT_MTIME     = 16'hBFF8;
    localparam logic [15:0] CLINT_MTIMEH    = 16'hBFFC;

    typedef enum logic {
        CLINT_IDLE,
        CLINT_ACK
    } clint_state_e;

    typedef struct packed {
        logic [15:0] offset;
        logic [31:0] wr_data;
        logic [3:0]  mask;
        logic        wr_en;
    } clint_req_t;

    // Replace the byte lanes of old_val selected by mask with those of new_val.
    function automatic logic [31:0] merge32(input logic [31:0] old_val,
                                            input logic [31:0] new_val,
                                            input logic [3:0]  mask);
        logic [31:0] res;
        res = old_val;
        for (int i = 0; i < 4; i++) begin
            if (mask[i]) res[i*8 +: 8] = new_val[i*8 +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/kronos_clint_tick.sv
// mtime prescaler: tick is high once every PRESCALE cycles (constantly high for PRESCALE=1).
module kronos_clint_tick #(
    parameter int unsigned PRESCALE = 1
) (
    input  logic clk,
    input  logic rstz,
    output logic tick
);

    localparam int unsigned CW = $clog2(PRESCALE + 1);

    logic [CW-1:0] count;

    assign tick = (count == CW'(PRESCALE - 1));

    always_ff @(posedge clk or negedge rstz) begin
        if (!rstz)     count <= '0;
        else if (tick) count <= '0;
        else           count <= count + CW'(1);
    end

endmodule

// File: rtl/kronos_clint.sv
// Core-local interruptor: msip / mtimecmp / mtime registers on the data bus,
// driving the software and timer interrupt lines.
module kronos_clint
    import kronos_types::*;
#(
    parameter int unsigned PRESCALE = 1
) (
    input  logic        clk,
    input  logic        rstz,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wr_data,
    input  logic [3:0]  data_mask,
    input  logic        data_wr_en,
    input  logic        data_req,
    output logic        data_ack,
    output logic [31:0] data_rd_data,
    output logic        software_interrupt,
    output logic        timer_interrupt
);

    clint_state_e state, state_nxt;
    clint_req_t   req;
    logic         accept;
    logic         tick;
    logic         msip;
    logic [63:0]  mtimecmp;
    logic [63:0]  mtime, mtime_nxt;
    logic [31:0]  rd_mux;
    logic         wr_any, wr_msip, wr_cmp, wr_cmph, wr_time, wr_timeh;
    logic         unused_addr;

    // Region decode happens upstream; only the word offset matters here.
    assign unused_addr = ^{data_addr[31:16], data_addr[1:0]};

    always_comb begin
        req.offset  = {data_addr[15:2], 2'b00};
        req.wr_data = data_wr_data;
        req.mask    = data_mask;
        req.wr_en   = data_wr_en;
    end

    kronos_clint_tick #(
        .PRESCALE (PRESCALE)
    ) u_tick (
        .clk  (clk),
        .rstz (rstz),
        .tick (tick)
    );

    // Bus FSM: a request is taken only in IDLE, so back-to-back accesses cost two cycles.
    always_ff @(posedge clk or negedge rstz) begin
        if (!rstz) state <= CLINT_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        case (state)
            CLINT_IDLE: begin
                if (data_req) begin
                    accept    = 1'b1;
                    state_nxt = CLINT_ACK;
                end
            end
            CLINT_ACK: state_nxt = CLINT_IDLE;
            default:   state_nxt = CLINT_IDLE;
        endcase
    end

    always_comb begin
        wr_any   = accept && req.wr_en && (req.mask != 4'b0000);
        wr_msip  = wr_any && (req.offset == CLINT_MSIP);
        wr_cmp   = wr_any && (req.offset == CLINT_MTIMECMP);
        wr_cmph  = wr_any && (req.offset == CLINT_MTIMECMPH);
        wr_time  = wr_any && (req.offset == CLINT_MTIME);
        wr_timeh = wr_any && (req.offset == CLINT_MTIMEH);
    end

    always_comb begin
        rd_mux = '0;
        case (req.offset)
            CLINT_MSIP:      rd_mux = {31'b0, msip};
            CLINT_MTIMECMP:  rd_mux = mtimecmp[31:0];
            CLINT_MTIMECMPH: rd_mux = mtimecmp[63:32];
            CLINT_MTIME:     rd_mux = mtime[31:0];
            CLINT_MTIMEH:    rd_mux = mtime[63:32];
            default:         rd_mux = '0;
        endcase
    end

    // A software write to either half suppresses the tick increment for that cycle.
    always_comb begin
        mtime_nxt = mtime;
        if (wr_time || wr_timeh) begin
            if (wr_time)  mtime_nxt[31:0]  = merge32(mtime[31:0], req.wr_data, req.mask);
            if (wr_timeh) mtime_nxt[63:32] = merge32(mtime[63:32], req.wr_data, req.mask);
        end else if (tick) begin
            mtime_nxt = mtime + 64'd1;
        end
    end

    always_ff @(posedge clk or negedge rstz) begin
        if (!rstz) begin
            data_ack     <= 1'b0;
            data_rd_data <= '0;
        end else begin
            data_ack <= accept;
            if (accept && !req.wr_en) data_rd_data <= rd_mux;
        end
    end

    always_ff @(posedge clk or negedge rstz) begin
        if (!rstz) begin
            msip     <= 1'b0;
            mtimecmp <= '1;
            mtime    <= '0;
        end else begin
            if (wr_msip) msip <= req.mask[0] ? req.wr_data[0] : msip;
            if (wr_cmp)  mtimecmp[31:0]  <= merge32(mtimecmp[31:0], req.wr_data, req.mask);
            if (wr_cmph) mtimecmp[63:32] <= merge32(mtimecmp[63:32], req.wr_data, req.mask);
            mtime <= mtime_nxt;
        end
    end

    always_ff @(posedge clk or negedge rstz) begin
        if (!rstz) begin
            software_interrupt <= 1'b0;
            timer_interrupt    <= 1'b0;
        end else begin
            software_interrupt <= msip;
            timer_interrupt    <= (mtime >= mtimecmp);
        end
    end

endmodule

// File: tb/tb_kronos_clint.sv
// Scoreboard bench for kronos_clint: expected read data is queued at issue and checked on data_ack.
module tb_kronos_clint;
    import kronos_types::*;

    logic        clk = 1'b0;
    logic        rstz;
    logic [31:0] data_addr;
    logic [31:0] data_wr_data;
    logic [3:0]  data_mask;
    logic        data_wr_en;
    logic        data_req;
    logic        data_ack;
    logic [31:0] data_rd_data;
    logic        software_interrupt;
    logic        timer_interrupt;

    typedef struct {
        bit          is_read;
        logic [31:0] val;
        string       tag;
    } exp_t;

    exp_t        exp_q[$];
    int unsigned n_vec  = 0;
    int unsigned n_miss = 0;
    int unsigned cyc    = 0;

    kronos_clint #(
        .PRESCALE (1)
    ) dut (
        .clk                (clk),
        .rstz               (rstz),
        .data_addr          (data_addr),
        .data_wr_data       (data_wr_data),
        .data_mask          (data_mask),
        .data_wr_en         (data_wr_en),
        .data_req           (data_req),
        .data_ack           (data_ack),
        .data_rd_data       (data_rd_data),
        .software_interrupt (software_interrupt),
        .timer_interrupt    (timer_interrupt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Every ack consumes one scoreboard entry; reads also compare the data.
    always @(negedge clk) begin
        if (data_ack) begin
            if (exp_q.size() == 0) begin
                check("spurious_ack", 64'(data_ack), 64'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (e.is_read) check(e.tag, 64'(data_rd_data), 64'(e.val));
            end
        end
    end

    // One bus access; when timed, the expected value advances one per cycle from ref_cyc.
    task automatic bus(input logic [15:0] off, input logic [31:0] wd, input logic [3:0] m,
                       input logic we, input logic [31:0] exp, input string tag,
                       input bit timed, input int unsigned ref_cyc, output int unsigned ack_cyc);
        exp_t e;
        bit   seen;
        @(negedge clk);
        e.is_read = !we;
        e.tag     = tag;
        e.val     = timed ? exp + 32'(cyc - ref_cyc) : exp;
        exp_q.push_back(e);
        data_addr    = {16'hA5A5, off[15:2], 2'b11};
        data_wr_data = wd;
        data_mask    = m;
        data_wr_en   = we;
        data_req     = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 8 && !seen; i++) begin
            @(negedge clk);
            seen = data_ack;
        end
        data_req = 1'b0;
        ack_cyc  = cyc;
        if (!seen) begin
            check({tag, "_ack_timeout"}, 64'd0, 64'd1);
            if (exp_q.size() > 0) void'(exp_q.pop_back());
        end
    endtask

    task automatic wr(input logic [15:0] off, input logic [31:0] wd, input logic [3:0] m,
                      output int unsigned ack_cyc);
        bus(off, wd, m, 1'b1, 32'h0, "wr", 1'b0, 0, ack_cyc);
    endtask

    task automatic rd(input logic [15:0] off, input logic [31:0] exp, input string tag);
        int unsigned c;
        bus(off, 32'h0, 4'h0, 1'b0, exp, tag, 1'b0, 0, c);
    endtask

    task automatic rd_t(input logic [15:0] off, input logic [31:0] base, input int unsigned ref_cyc,
                        input string tag);
        int unsigned c;
        bus(off, 32'h0, 4'h0, 1'b0, base, tag, 1'b1, ref_cyc, c);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int unsigned c, t0, hits;
        bit seen;
        rstz = 1'b0; data_addr = '0; data_wr_data = '0; data_mask = '0;
        data_wr_en = 1'b0; data_req = 1'b0;
        repeat (3) @(negedge clk);
        rstz = 1'b1;
        @(negedge clk);
        check("rst_ack", 64'(data_ack), 64'd0);
        check("rst_rd_data", 64'(data_rd_data), 64'd0);
        check("rst_sw_irq", 64'(software_interrupt), 64'd0);
        check("rst_timer_irq", 64'(timer_interrupt), 64'd0);
        rd(CLINT_MTIMECMPH, 32'hFFFF_FFFF, "rst_cmph");
        rd(CLINT_MTIMECMP, 32'hFFFF_FFFF, "rst_cmp");
        hits = 0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (timer_interrupt) hits++;
        end
        check("timer_quiet_1000", 64'(hits), 64'd0);

        // Software interrupt
        wr(CLINT_MSIP, 32'hFFFF_FFFF, 4'hF, c);
        check("sw_irq_at_ack", 64'(software_interrupt), 64'd0);
        @(negedge clk);
        check("sw_irq_set", 64'(software_interrupt), 64'd1);
        rd(CLINT_MSIP, 32'h1, "msip_rb");
        wr(CLINT_MSIP, 32'h0, 4'hF, c);
        check("sw_irq_hold", 64'(software_interrupt), 64'd1);
        @(negedge clk);
        check("sw_irq_clr", 64'(software_interrupt), 64'd0);

        // Byte-lane merge and zero-mask no-op
        wr(CLINT_MTIMECMP, 32'h1122_3344, 4'hF, c);
        wr(CLINT_MTIMECMP, 32'hAABB_CCDD, 4'b0101, c);
        rd(CLINT_MTIMECMP, 32'h11BB_33DD, "mask_merge");
        wr(CLINT_MTIMECMP, 32'h0000_0000, 4'b0000, c);
        rd(CLINT_MTIMECMP, 32'h11BB_33DD, "mask_zero");

        // Timer fire at mtime == 50
        wr(CLINT_MTIMECMP, 32'd50, 4'hF, c);
        wr(CLINT_MTIMEH, 32'h0, 4'hF, c);
        wr(CLINT_MTIME, 32'h0, 4'hF, t0);
        wr(CLINT_MTIMECMPH, 32'h0, 4'hF, c);
        rd_t(CLINT_MTIME, 32'h0, t0, "mtime_count");
        check("timer_before", 64'(timer_interrupt), 64'd0);
        seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clk);
            seen = timer_interrupt;
        end
        check("timer_rise_cycle", 64'(cyc - t0), 64'd51);
        wr(CLINT_MTIMECMP, 32'hFFFF_FFFF, 4'hF, c);
        check("timer_hold_ack", 64'(timer_interrupt), 64'd1);
        @(negedge clk);
        check("timer_drop", 64'(timer_interrupt), 64'd0);

        // 64-bit wrap
        wr(CLINT_MTIMEH, 32'hFFFF_FFFF, 4'hF, c);
        wr(CLINT_MTIME, 32'hFFFF_FFFF, 4'hF, t0);
        @(negedge clk);
        check("wrap_timer_hi", 64'(timer_interrupt), 64'd1);
        @(negedge clk);
        check("wrap_timer_fall", 64'(timer_interrupt), 64'd0);
        rd(CLINT_MTIMEH, 32'h0, "wrap_hi");
        rd_t(CLINT_MTIME, 32'hFFFF_FFFF, t0, "wrap_lo");

        // Write colliding with tick stores exactly; no carry into the high half
        wr(CLINT_MTIME, 32'h1234_5678, 4'hF, t0);
        rd_t(CLINT_MTIME, 32'h1234_5678, t0, "collide_lo");
        rd(CLINT_MTIMEH, 32'h0, "collide_hi");

        // req held 6 cycles: three accepted reads
        @(negedge clk);
        for (int i = 0; i < 3; i++) exp_q.push_back('{1'b1, 32'h0, "held_req_rd"});
        data_addr = {16'h0, CLINT_MSIP}; data_wr_en = 1'b0; data_mask = 4'h0; data_req = 1'b1;
        hits = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (data_ack) hits++;
        end
        data_req = 1'b0;
        check("held_req_acks", 64'(hits), 64'd3);

        // Unmapped offset
        wr(16'h1234, 32'hDEAD_BEEF, 4'hF, c);
        rd(16'h1234, 32'h0, "unmapped_rd");

        // Reset pulse during the ACK cycle
        @(negedge clk);
        data_addr = {16'h0, CLINT_MSIP}; data_wr_data = 32'h1; data_mask = 4'hF;
        data_wr_en = 1'b1; data_req = 1'b1;
        @(posedge clk);
        #2;
        rstz = 1'b0;
        data_req = 1'b0;
        @(negedge clk);
        check("rst_mid_ack", 64'(data_ack), 64'd0);
        rstz = 1'b1;
        hits = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (data_ack) hits++;
        end
        check("rst_no_late_ack", 64'(hits), 64'd0);
        rd(CLINT_MSIP, 32'h0, "rst_msip");
        rd(CLINT_MTIMECMPH, 32'hFFFF_FFFF, "rst_cmph_again");

        @(negedge clk);
        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
